envelope_follower: RTL and testbench
====================================

Name: envelope_follower

Overview:
- Analysis-direction counterpart to the gated attack/release voice path: derives an 8-bit envelope level and a gate from an incoming audio stream.
- The voice path consumes a gate and produces a shaped sample; this block consumes samples and produces level and gate.
- Sits after the mixer, or on an external audio input. Drives sidechain ducking, auto-gating of voices, and the VU meter register.
- One sample per sample_clock edge.

Parameters:
- BITDEPTH, 14, width of the signed two's-complement input sample.
- HYST, 8, gate close hysteresis in level units (0..255).

Ports:
- sample_clock  input  1  sample-rate clock; every rising edge is one sample.
- rst  input  1  asynchronous, active-low reset.
- in  input  BITDEPTH  signed audio sample.
- attack  input  8  rise rate; step per sample = attack+1 accumulator units.
- release  input  8  fall rate; step per sample = release+1 accumulator units.
- threshold  input  8  gate open level.
- hold  input  8  samples the gate stays open after level drops below the close threshold.
- level  output  8  current envelope level.
- gate  output  1  high while the detector state is OPEN or HOLD.

Behaviour:
- Reset (rst low, async): acc=0, level=0, state=CLOSED, gate=0, hold counter=0. All registers clear immediately, including mid-attack or mid-hold.
- Rectify (combinational):
  - mag = |in|, BITDEPTH-1 bits.
  - Most-negative input saturates to max positive (e.g. -8192 -> 8191).
  - mag8 = top 8 bits of mag, i.e. mag[BITDEPTH-2 -: 8]. For BITDEPTH=14 this is mag[12:5].
- Accumulator: 16-bit unsigned acc; level = acc[15:8] (registered, no combinational path from in). Each edge, with target = {mag8, 8'h00}:
  - target > acc: acc <= min(acc + attack + 1, target).
  - target < acc: acc <= max(acc - (release + 1), target).
  - target == acc: hold value.
  - No wrap: clamping to target guarantees 0 <= acc <= 0xFF00.
- Rate examples: attack=255 gives +1 level per sample; attack=0 gives +1 level per 256 samples. Release behaves the same way downward.
- Gate FSM, evaluated on the registered level (the pre-update value):
  - close_thr = threshold - HYST, saturating at 0.
  - CLOSED: if level >= threshold -> OPEN.
  - OPEN: if level < close_thr -> HOLD, loading cnt <= hold. Otherwise stay OPEN.
  - HOLD:
    - level >= threshold -> OPEN (retrigger; counter abandoned).
    - Else cnt == 0 -> CLOSED.
    - Else cnt <= cnt - 1.
  - gate is the registered decode of the next state, so it changes on the same edge as the state.
- Boundary cases:
  - threshold=0: the gate opens on the first edge after reset and never closes.
  - threshold < HYST: close_thr=0, so the gate never closes once open.
  - hold=0: exactly one sample in HOLD, then CLOSED.
  - HOLD duration is hold+1 samples when not retriggered.
- Latency:
  - in -> level: 1 edge.
  - level crossing -> gate change: 1 further edge.
- Control inputs (attack, release, threshold, hold) may change at any edge and take effect on that edge's computation. hold is sampled only on OPEN->HOLD entry.

Test Plan:
- Attack ramp: reset, in=8191, attack=255, release=0, threshold=64 -> level=k after k edges, saturating at 255 on edge 255. Gate goes 1 on edge 65 (level reaches 64 at edge 64).
- Release with hold: after the ramp, in=0, release=255, hold=10, HYST=8 -> level falls 1 per edge. Enter HOLD on the edge after level reads 55; gate stays 1 for 11 edges in HOLD, then 0. Level ends at 0 and stays there.
- Retrigger: during HOLD (cnt=5), apply in=8191 with attack=255 -> state returns to OPEN on the edge level reads >=64, and gate never drops.
- Negative full scale and rectify: in=-8192 constant, attack=255 -> identical level trajectory to in=8191. Then in=-32 -> mag8=1, and level decays to 1 and holds.
- Slow attack clamp: attack=0, in=1024 (mag8=32) from reset -> level=1 after 256 edges, level=32 after 8192 edges, and acc is exactly 0x2000 with no overshoot.
- Async reset: assert rst low mid-ramp between clock edges -> level=0 and gate=0 immediately without a clock. On release with in=0 and threshold=0, gate=1 after the first edge.

Source files
------------

// File: rtl/envelope_follower.sv
// Envelope follower: rectifies a signed audio stream into an 8-bit level with
// independent attack/release slew, and derives a hysteretic gate with hold time.
module envelope_follower #(
  parameter int unsigned BITDEPTH = 14,
  parameter int unsigned HYST     = 8
) (
  input  logic                       sample_clock,
  input  logic                       rst,
  input  logic signed [BITDEPTH-1:0] in,
  input  logic        [7:0]          attack,
  input  logic        [7:0]          release_rate,
  input  logic        [7:0]          threshold,
  input  logic        [7:0]          hold,
  output logic        [7:0]          level,
  output logic                       gate
);

  localparam int unsigned MagW = BITDEPTH - 1;
  localparam logic [8:0]  Hyst9 = 9'(HYST);

  typedef enum logic [1:0] {StClosed, StOpen, StHold} state_e;

  // Rectifier
  logic [BITDEPTH-1:0] neg;
  logic [MagW-1:0]     mag;
  logic [7:0]          mag8;

  always_comb begin
    neg = (~in) + {{(BITDEPTH-1){1'b0}}, 1'b1};
    if (!in[BITDEPTH-1]) begin
      mag = in[MagW-1:0];
    end else if (in[BITDEPTH-2:0] == '0) begin
      mag = '1;  // most-negative code has no positive twin; saturate
    end else begin
      mag = neg[MagW-1:0];
    end
    mag8 = mag[MagW-1 -: 8];
  end

  // Slewing accumulator
  logic [15:0] acc_q, acc_d, target;
  logic [16:0] rise_sum, fall_floor;

  always_comb begin
    target     = {mag8, 8'h00};
    rise_sum   = {1'b0, acc_q} + {9'b0, attack} + 17'd1;
    fall_floor = {1'b0, target} + {9'b0, release_rate} + 17'd1;
    acc_d      = acc_q;
    if (target > acc_q) begin
      acc_d = (rise_sum > {1'b0, target}) ? target : rise_sum[15:0];
    end else if (target < acc_q) begin
      // Clamp whenever a full step would land below the target.
      acc_d = ({1'b0, acc_q} < fall_floor) ? target
                                           : acc_q - {8'b0, release_rate} - 16'd1;
    end
  end

  always_ff @(posedge sample_clock or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign level = acc_q[15:8];

  // Gate detector
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] close_thr;
  logic       gate_q, gate_d;

  always_comb begin
    if ({1'b0, threshold} >= Hyst9) begin
      close_thr = threshold - Hyst9[7:0];
    end else begin
      close_thr = 8'd0;
    end
  end

  always_ff @(posedge sample_clock or negedge rst) begin
    if (!rst) begin
      state_q <= StClosed;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StClosed: begin
        if (level >= threshold) state_d = StOpen;
      end
      StOpen: begin
        if (level < close_thr) begin
          state_d = StHold;
          cnt_d   = hold;
        end
      end
      StHold: begin
        if (level >= threshold) begin
          state_d = StOpen;
        end else if (cnt_q == 8'd0) begin
          state_d = StClosed;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StClosed;
    endcase
  end

  // Gate is registered from the next state so it moves on the same edge.
  always_comb begin
    gate_d = (state_d != StClosed);
  end

  assign gate = gate_q;

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower: per-edge ramp/release sequences,
// a table of segment vectors, slow-attack clamp and asynchronous reset.
module tb_envelope_follower;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] in;
  logic [7:0]  attack, rel, threshold, hold;
  logic [7:0]  level;
  logic        gate;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  envelope_follower #(.BITDEPTH(14), .HYST(8)) dut (
    .sample_clock (clk),
    .rst          (rst),
    .in           (in),
    .attack       (attack),
    .release_rate (rel),
    .threshold    (threshold),
    .hold         (hold),
    .level        (level),
    .gate         (gate)
  );

  typedef struct {
    logic        do_rst;
    logic [13:0] in;
    logic [7:0]  att;
    logic [7:0]  rel;
    logic [7:0]  thr;
    logic [7:0]  hold;
    int          edges;
    logic [7:0]  exp_level;
    logic        exp_gate;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic set_in(input logic [13:0] i_in, input int a, input int r, input int t,
                        input int h);
    in        = i_in;
    attack    = 8'(a);
    rel       = 8'(r);
    threshold = 8'(t);
    hold      = 8'(h);
  endtask

  task automatic add(input logic r, input logic [13:0] i_in, input int a, input int rl,
                     input int t, input int h, input int e, input int el, input logic eg);
    vec_t v;
    v.do_rst    = r;
    v.in        = i_in;
    v.att       = 8'(a);
    v.rel       = 8'(rl);
    v.thr       = 8'(t);
    v.hold      = 8'(h);
    v.edges     = e;
    v.exp_level = 8'(el);
    v.exp_gate  = eg;
    vecs.push_back(v);
  endtask

  initial begin
    // Retrigger from HOLD (cnt=5) by raising level and lowering threshold.
    add(1, 14'd8191, 255,   0, 64, 10, 64, 64, 0);
    add(0, 14'd8191, 255,   0, 64, 10,  1, 65, 1);
    add(0, 14'd0,    255, 255, 64, 10,  1, 64, 1);
    add(0, 14'd0,    255, 255, 64, 10,  9, 55, 1);
    add(0, 14'd0,    255, 255, 64, 10,  1, 54, 1);
    add(0, 14'd0,    255, 255, 64, 10,  5, 49, 1);
    add(0, 14'd8191, 255, 255, 52, 10,  3, 52, 1);
    add(0, 14'd8191, 255, 255, 52, 10,  1, 53, 1);
    add(0, 14'd0,    255, 255, 52, 10,  5, 48, 1);
    // Negative full scale and small negative rectification.
    add(1, 14'h2000, 255,   0, 64, 10, 64, 64, 0);
    add(0, 14'h2000, 255,   0, 64, 10,  1, 65, 1);
    add(0, 14'h3FE0, 255, 255, 64, 10, 64,  1, 0);
    add(0, 14'h3FE0, 255, 255, 64, 10, 50,  1, 0);
    add(0, 14'h3FE1, 255, 255, 64, 10,  1,  0, 0);
    // threshold below HYST: gate never closes.
    add(1, 14'd8191, 255,   0,  5, 10, 10, 10, 1);
    add(0, 14'd0,    255, 255,  5, 10, 40,  0, 1);
    // threshold zero.
    add(1, 14'd0,      0,   0,  0,  0,  1,  0, 1);
    add(0, 14'd0,      0,   0,  0,  0, 20,  0, 1);
    // hold=0: exactly one sample in HOLD.
    add(1, 14'd8191, 255,   0, 20,  0, 30, 30, 1);
    add(0, 14'd0,    255, 255, 20,  0, 19, 11, 1);
    add(0, 14'd0,    255, 255, 20,  0,  1, 10, 1);
    add(0, 14'd0,    255, 255, 20,  0,  1,  9, 0);
    // Intermediate rates and mid-scale target clamp.
    add(1, 14'd8191, 127,   0, 255, 0, 10,  5, 0);
    add(1, 14'd4096, 255,   0, 255, 0, 200, 128, 0);
    add(0, 14'd0,      0, 127, 255, 0, 20, 118, 0);

    // Reset state before any clock edge.
    set_in(14'd8191, 255, 0, 64, 10);
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset_level", 32'(level), 32'd0);
    check("reset_gate", 32'(gate), 32'd0);
    rst = 1'b1;

    // Attack ramp, one level per edge.
    for (int k = 1; k <= 260; k++) begin
      tick(1);
      check($sformatf("ramp_level_k%0d", k), 32'(level), (k > 255) ? 32'd255 : 32'(k));
      check($sformatf("ramp_gate_k%0d", k), 32'(gate), (k >= 65) ? 32'd1 : 32'd0);
    end

    // Release with hold=10: HOLD entered at edge 201, closes at edge 212.
    set_in(14'd0, 255, 255, 64, 10);
    for (int j = 1; j <= 260; j++) begin
      tick(1);
      check($sformatf("rel_level_j%0d", j), 32'(level), (j >= 255) ? 32'd0 : 32'(255 - j));
      check($sformatf("rel_gate_j%0d", j), 32'(gate), (j <= 211) ? 32'd1 : 32'd0);
    end

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      in        = vecs[i].in;
      attack    = vecs[i].att;
      rel       = vecs[i].rel;
      threshold = vecs[i].thr;
      hold      = vecs[i].hold;
      tick(vecs[i].edges);
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_gate", i), 32'(gate), 32'(vecs[i].exp_gate));
    end

    // Slow attack clamps exactly at target.
    do_reset();
    set_in(14'd1024, 0, 0, 255, 0);
    tick(255);
    check("slow_level_255", 32'(level), 32'd0);
    tick(1);
    check("slow_level_256", 32'(level), 32'd1);
    tick(7936);
    check("slow_level_8192", 32'(level), 32'd32);
    check("slow_acc_8192", 32'(dut.acc_q), 32'h2000);
    tick(100);
    check("slow_level_hold", 32'(level), 32'd32);
    check("slow_acc_hold", 32'(dut.acc_q), 32'h2000);
    check("slow_gate", 32'(gate), 32'd0);

    // Asynchronous reset mid-ramp, between edges.
    do_reset();
    set_in(14'd8191, 255, 0, 64, 10);
    tick(70);
    check("pre_async_level", 32'(level), 32'd70);
    #3;
    rst = 1'b0;
    #1;
    check("async_level", 32'(level), 32'd0);
    check("async_gate", 32'(gate), 32'd0);
    set_in(14'd0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    check("async_gate_pre_edge", 32'(gate), 32'd0);
    tick(1);
    check("async_gate_edge1", 32'(gate), 32'd1);
    check("async_level_edge1", 32'(level), 32'd0);
    tick(5);
    check("async_gate_edge6", 32'(gate), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
